// File: rtl/sap_sequencer.sv
// SAP-1 style ring-counter sequencer: fetch/execute T-states, opcode decode
// into the 15-bit datapath control word, variable-length ring, sticky halt.
// Ports: clk_i (falling-edge state), rstn_i (async, active-low),
//        opcode_i, zero_i, carry_i in; ctrl_word_o, t_state_o,
//        instr_done_o, hltn_o out.
module sap_sequencer #(
    parameter int OP_W      = 4,
    parameter int NUM_T     = 6,
    parameter bit EARLY_END = 1'b1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [OP_W-1:0]  opcode_i,
    input  logic             zero_i,
    input  logic             carry_i,
    output logic [14:0]      ctrl_word_o,
    output logic [NUM_T-1:0] t_state_o,
    output logic             instr_done_o,
    output logic             hltn_o
);

    localparam logic [14:0] PC_INC     = 15'h0001;
    localparam logic [14:0] PC_EN      = 15'h0002;
    localparam logic [14:0] MAR_LOAD   = 15'h0004;
    localparam logic [14:0] RAM_EN     = 15'h0008;
    localparam logic [14:0] IR_LOAD    = 15'h0010;
    localparam logic [14:0] IR_EN      = 15'h0020;
    localparam logic [14:0] A_LOAD     = 15'h0040;
    localparam logic [14:0] A_EN       = 15'h0080;
    localparam logic [14:0] ALU_EN     = 15'h0100;
    localparam logic [14:0] ALU_SUB    = 15'h0200;
    localparam logic [14:0] B_LOAD     = 15'h0400;
    localparam logic [14:0] OUT_LOAD   = 15'h0800;
    localparam logic [14:0] PC_LOAD    = 15'h1000;
    localparam logic [14:0] FLAGS_LOAD = 15'h2000;
    localparam logic [14:0] RAM_WE     = 15'h4000;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_STA = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JZ  = 4'd5;
    localparam logic [3:0] OP_JC  = 4'd6;
    localparam logic [3:0] OP_OUT = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    localparam logic [NUM_T-1:0] T1 = {{(NUM_T-1){1'b0}}, 1'b1};

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } mode_e;

    mode_e            r_mode;
    logic [NUM_T-1:0] r_ring;

    logic [3:0]       w_op;
    logic [NUM_T-1:0] w_ring_m1;
    logic             w_onehot;
    logic             w_last;
    logic             w_active;
    logic [14:0]      w_dec;

    // Only the top four opcode bits select the instruction.
    assign w_op      = opcode_i[OP_W-1 -: 4];

    // x & (x-1) clears the lowest set bit; zero result means one-hot.
    assign w_ring_m1 = r_ring - T1;
    assign w_onehot  = (|r_ring) && ~(|(r_ring & w_ring_m1));

    assign w_active  = rstn_i && (r_mode == S_RUN) && w_onehot;

    // Last active execute step for the current opcode.
    always_comb begin
        w_last = r_ring[3];
        case (w_op)
            OP_LDA, OP_STA: w_last = r_ring[4];
            OP_ADD, OP_SUB: w_last = r_ring[5];
            default:        w_last = r_ring[3];
        endcase
    end

    // Steps past an instruction's end decode to zero, which gives the
    // NOP padding of fixed-length mode for free.
    always_comb begin
        w_dec = '0;
        if (r_ring[0]) begin
            w_dec = PC_EN | MAR_LOAD;
        end else if (r_ring[1]) begin
            w_dec = PC_INC;
        end else if (r_ring[2]) begin
            w_dec = RAM_EN | IR_LOAD;
        end else if (r_ring[3]) begin
            case (w_op)
                OP_LDA, OP_ADD, OP_SUB, OP_STA:
                    w_dec = IR_EN | MAR_LOAD;
                OP_JMP: w_dec = IR_EN | PC_LOAD;
                OP_JZ:  w_dec = zero_i  ? (IR_EN | PC_LOAD) : '0;
                OP_JC:  w_dec = carry_i ? (IR_EN | PC_LOAD) : '0;
                OP_OUT: w_dec = A_EN | OUT_LOAD;
                default: w_dec = '0;
            endcase
        end else if (r_ring[4]) begin
            case (w_op)
                OP_LDA:         w_dec = RAM_EN | A_LOAD;
                OP_ADD, OP_SUB: w_dec = RAM_EN | B_LOAD;
                OP_STA:         w_dec = A_EN | RAM_WE;
                default:        w_dec = '0;
            endcase
        end else if (r_ring[5]) begin
            case (w_op)
                OP_ADD:  w_dec = ALU_EN | A_LOAD | FLAGS_LOAD;
                OP_SUB:  w_dec = ALU_EN | ALU_SUB | A_LOAD | FLAGS_LOAD;
                default: w_dec = '0;
            endcase
        end
    end

    always_ff @(negedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_ring <= T1;
            r_mode <= S_RUN;
        end else if (r_mode == S_RUN) begin
            if (!w_onehot) begin
                r_ring <= T1;
            end else if (r_ring[3] && (w_op == OP_HLT)) begin
                r_ring <= '0;
                r_mode <= S_HALT;
            end else if (EARLY_END && w_last) begin
                r_ring <= T1;
            end else if (r_ring[NUM_T-1]) begin
                r_ring <= T1;
            end else begin
                r_ring <= {r_ring[NUM_T-2:0], 1'b0};
            end
        end
    end

    assign ctrl_word_o  = w_active ? w_dec : '0;
    assign instr_done_o = w_active &&
                          (EARLY_END ? w_last : r_ring[NUM_T-1]);
    assign t_state_o    = r_ring;
    assign hltn_o       = (r_mode == S_RUN);

endmodule

// File: tb/tb_sap_sequencer.sv
// Directed bench for sap_sequencer: one early-end instance (NUM_T=6)
// and one fixed-length instance (NUM_T=8) sharing stimulus.
module tb_sap_sequencer;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [3:0]  op = 4'd0;
    logic        zero = 1'b0;
    logic        carry = 1'b0;

    logic [14:0] cw_e, cw_f;
    logic [5:0]  ts_e;
    logic [7:0]  ts_f;
    logic        done_e, done_f, hltn_e, hltn_f;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    sap_sequencer #(.OP_W(4), .NUM_T(6), .EARLY_END(1'b1)) u_e (
        .clk_i(clk), .rstn_i(rstn), .opcode_i(op),
        .zero_i(zero), .carry_i(carry),
        .ctrl_word_o(cw_e), .t_state_o(ts_e),
        .instr_done_o(done_e), .hltn_o(hltn_e)
    );

    sap_sequencer #(.OP_W(4), .NUM_T(8), .EARLY_END(1'b0)) u_f (
        .clk_i(clk), .rstn_i(rstn), .opcode_i(op),
        .zero_i(zero), .carry_i(carry),
        .ctrl_word_o(cw_f), .t_state_o(ts_f),
        .instr_done_o(done_f), .hltn_o(hltn_f)
    );

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rstn = 1'b0;
        #2 rstn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        checks++;
        if (cw_e !== 15'h0000 || cw_f !== 15'h0000) begin
            $display("FAIL reset_ctrl got %h/%h want 0000", cw_e, cw_f);
            fails++;
        end
        checks++;
        if (ts_e !== 6'h01 || ts_f !== 8'h01) begin
            $display("FAIL reset_tstate got %h/%h want 01", ts_e, ts_f);
            fails++;
        end
        checks++;
        if (done_e !== 1'b0 || done_f !== 1'b0 ||
            hltn_e !== 1'b1 || hltn_f !== 1'b1) begin
            $display("FAIL reset_flags done %b/%b hltn %b/%b want 0/0 1/1",
                     done_e, done_f, hltn_e, hltn_f);
            fails++;
        end
        #1 rstn = 1'b1;
    endtask

    task automatic test_lda_early();
        logic [14:0] exp_cw [6];
        exp_cw = '{15'h0006, 15'h0001, 15'h0018,
                   15'h0024, 15'h0048, 15'h0006};
        op = 4'd0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (cw_e !== exp_cw[i] || ts_e !== 6'(1 << (i % 5)) ||
                done_e !== (i == 4)) begin
                $display("FAIL lda_early step %0d got cw=%h ts=%h done=%b want cw=%h ts=%h done=%b",
                         i, cw_e, ts_e, done_e, exp_cw[i],
                         6'(1 << (i % 5)), (i == 4));
                fails++;
            end
            step();
        end
    endtask

    task automatic test_sub_fixed();
        logic [14:0] exp_cw [9];
        exp_cw = '{15'h0006, 15'h0001, 15'h0018, 15'h0024, 15'h0408,
                   15'h2340, 15'h0000, 15'h0000, 15'h0006};
        op = 4'd2;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (cw_f !== exp_cw[i] || ts_f !== 8'(1 << (i % 8)) ||
                done_f !== (i == 7)) begin
                $display("FAIL sub_fixed step %0d got cw=%h ts=%h done=%b want cw=%h ts=%h done=%b",
                         i, cw_f, ts_f, done_f, exp_cw[i],
                         8'(1 << (i % 8)), (i == 7));
                fails++;
            end
            step();
        end
    endtask

    task automatic test_opcode_ignore();
        logic [14:0] exp_cw [3];
        exp_cw = '{15'h0006, 15'h0001, 15'h0018};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            op = 4'($urandom_range(0, 15));
            #1;
            checks++;
            if (cw_e !== exp_cw[i]) begin
                $display("FAIL fetch_ignore_op T%0d op=%h got %h want %h",
                         i + 1, op, cw_e, exp_cw[i]);
                fails++;
            end
            step();
        end
        op = 4'd0;
    endtask

    task automatic test_cond_jumps();
        zero = 1'b0;
        op = 4'd5;
        do_reset();
        step(); step(); step();
        checks++;
        if (ts_e !== 6'h08 || cw_e !== 15'h0000 || done_e !== 1'b1) begin
            $display("FAIL jz_not_taken got ts=%h cw=%h done=%b want 08 0000 1",
                     ts_e, cw_e, done_e);
            fails++;
        end
        zero = 1'b1;
        #1;
        checks++;
        if (cw_e !== 15'h1020 || cw_f !== 15'h1020) begin
            $display("FAIL jz_taken_in_t4 got %h/%h want 1020", cw_e, cw_f);
            fails++;
        end
        step();
        checks++;
        if (ts_e !== 6'h01) begin
            $display("FAIL jz_return_t1 got ts=%h want 01", ts_e);
            fails++;
        end
        zero = 1'b0;
        carry = 1'b1;
        op = 4'd6;
        do_reset();
        step(); step(); step();
        checks++;
        if (cw_e !== 15'h1020) begin
            $display("FAIL jc_taken got %h want 1020", cw_e);
            fails++;
        end
        carry = 1'b0;
        #1;
        checks++;
        if (cw_e !== 15'h0000) begin
            $display("FAIL jc_not_taken got %h want 0000", cw_e);
            fails++;
        end
        step();
        checks++;
        if (ts_e !== 6'h01) begin
            $display("FAIL jc_return_t1 got ts=%h want 01", ts_e);
            fails++;
        end
    endtask

    task automatic test_sta_out();
        op = 4'd3;
        do_reset();
        step(); step(); step(); step();
        checks++;
        if (cw_e !== 15'h4080 || done_e !== 1'b1 || ts_e !== 6'h10) begin
            $display("FAIL sta_t5 got cw=%h done=%b ts=%h want 4080 1 10",
                     cw_e, done_e, ts_e);
            fails++;
        end
        op = 4'd14;
        do_reset();
        step(); step(); step();
        checks++;
        if (cw_e !== 15'h0880 || done_e !== 1'b1) begin
            $display("FAIL out_t4 got cw=%h done=%b want 0880 1",
                     cw_e, done_e);
            fails++;
        end
        step();
        checks++;
        if (ts_e !== 6'h01 || cw_e !== 15'h0006) begin
            $display("FAIL out_return_t1 got ts=%h cw=%h want 01 0006",
                     ts_e, cw_e);
            fails++;
        end
    endtask

    task automatic test_halt();
        op = 4'd15;
        do_reset();
        step(); step(); step();
        checks++;
        if (cw_e !== 15'h0000 || done_e !== 1'b1 || hltn_e !== 1'b1) begin
            $display("FAIL hlt_t4 got cw=%h done=%b hltn=%b want 0000 1 1",
                     cw_e, done_e, hltn_e);
            fails++;
        end
        step();
        checks++;
        if (hltn_e !== 1'b0 || ts_e !== 6'h00 ||
            hltn_f !== 1'b0 || ts_f !== 8'h00) begin
            $display("FAIL hlt_enter got hltn=%b/%b ts=%h/%h want 0/0 00/00",
                     hltn_e, hltn_f, ts_e, ts_f);
            fails++;
        end
        for (int i = 0; i < 10; i++) begin
            op = 4'($urandom_range(0, 15));
            zero = ~zero;
            step();
            checks++;
            if (ts_e !== 6'h00 || cw_e !== 15'h0000 ||
                done_e !== 1'b0 || hltn_e !== 1'b0) begin
                $display("FAIL hlt_frozen cyc %0d got ts=%h cw=%h done=%b hltn=%b want 00 0000 0 0",
                         i, ts_e, cw_e, done_e, hltn_e);
                fails++;
            end
        end
        zero = 1'b0;
        op = 4'd0;
        do_reset();
        checks++;
        if (hltn_e !== 1'b1 || ts_e !== 6'h01 || cw_e !== 15'h0006) begin
            $display("FAIL hlt_exit_reset got hltn=%b ts=%h cw=%h want 1 01 0006",
                     hltn_e, ts_e, cw_e);
            fails++;
        end
    endtask

    task automatic test_reset_mid();
        op = 4'd1;
        do_reset();
        step(); step(); step(); step();
        checks++;
        if (cw_e !== 15'h0408) begin
            $display("FAIL add_t5 got %h want 0408", cw_e);
            fails++;
        end
        #1 rstn = 1'b0;
        #1;
        checks++;
        if (cw_e !== 15'h0000 || ts_e !== 6'h01 || done_e !== 1'b0) begin
            $display("FAIL mid_reset got cw=%h ts=%h done=%b want 0000 01 0",
                     cw_e, ts_e, done_e);
            fails++;
        end
        #1 rstn = 1'b1;
        #1;
        checks++;
        if (cw_e !== 15'h0006) begin
            $display("FAIL mid_reset_t1 got %h want 0006", cw_e);
            fails++;
        end
        step();
        checks++;
        if (cw_e !== 15'h0001 || ts_e !== 6'h02) begin
            $display("FAIL mid_reset_t2 got cw=%h ts=%h want 0001 02",
                     cw_e, ts_e);
            fails++;
        end
    endtask

    initial begin
        test_reset();
        test_lda_early();
        test_sub_fixed();
        test_opcode_ignore();
        test_cond_jumps();
        test_sta_out();
        test_halt();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached 100000 ns");
        $fatal(1);
    end

endmodule
